// File: rtl/multi_servo_ctrl.sv
// multi_servo_ctrl: NUM_CH hobby-servo PWM generators sharing one frame
// counter and one slow update tick. Each channel keeps a target (buttons or
// direct write), a position that slews toward the target once per tick, and
// a duty latched from position at the end of each frame.
// Optional build macro: SERVO_STAGGER_EN spreads channel pulse starts evenly
// across the frame instead of rising all channels together.

module servo_ch #(
    parameter int PW         = 25,
    parameter int FRAME_TICK = 1000000,
    parameter int PULSE_MIN  = 35000,
    parameter int PULSE_MAX  = 115000,
    parameter int STEP_SIZE  = 2000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_tick,
    input  logic          i_inc,
    input  logic          i_dec,
    input  logic          i_wr,
    input  logic [PW-1:0] i_wr_val,
    input  logic [PW-1:0] i_phase,
    output logic          o_servo,
    output logic          o_at_target
);
    localparam logic [PW-1:0] L_MIN    = PW'(PULSE_MIN);
    localparam logic [PW-1:0] L_MAX    = PW'(PULSE_MAX);
    localparam logic [PW-1:0] L_STEP   = PW'(STEP_SIZE);
    localparam logic [PW-1:0] L_FT_M1  = PW'(FRAME_TICK - 1);
    // Clamp thresholds compared before add/subtract so nothing wraps.
    localparam logic [PW-1:0] L_DN_LIM = PW'(PULSE_MIN + STEP_SIZE);
    localparam logic [PW-1:0] L_UP_LIM = PW'(PULSE_MAX - STEP_SIZE);

    logic [PW-1:0] r_target, r_position, r_duty;
    logic          r_servo;
    logic [PW-1:0] w_tgt_up, w_tgt_dn, w_pos_nxt;

    // Saturating button steps and one slew step of position toward target.
    always_comb begin
        w_tgt_up = (r_target >= L_UP_LIM) ? L_MAX : r_target + L_STEP;
        w_tgt_dn = (r_target <= L_DN_LIM) ? L_MIN : r_target - L_STEP;
        if (r_target > r_position)
            w_pos_nxt = (r_target - r_position <= L_STEP) ? r_target : r_position + L_STEP;
        else
            w_pos_nxt = (r_position - r_target <= L_STEP) ? r_target : r_position - L_STEP;
    end

    // Target: a direct write overrides a same-cycle button step; r beats l.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 r_target <= L_MIN;
        else if (i_wr)            r_target <= i_wr_val;
        else if (i_tick && i_inc) r_target <= w_tgt_up;
        else if (i_tick && i_dec) r_target <= w_tgt_dn;
    end

    // Position slews on the tick using the pre-tick target; duty only
    // reloads at the last phase count so a frame never changes width.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_position <= L_MIN;
            r_duty     <= L_MIN;
            r_servo    <= 1'b0;
        end else begin
            if (i_tick)             r_position <= w_pos_nxt;
            if (i_phase == L_FT_M1) r_duty     <= r_position;
            r_servo <= (i_phase < r_duty);
        end
    end

    assign o_servo     = r_servo;
    assign o_at_target = (r_position == r_target);
endmodule

module multi_servo_ctrl #(
    parameter int NUM_CH        = 4,
    parameter int FRAME_TICK    = 1000000,
    parameter int PULSE_MIN     = 35000,
    parameter int PULSE_MAX     = 115000,
    parameter int STEP_SIZE     = 2000,
    parameter int SLOW_TICK_MAX = 5000000,
    parameter int PW            = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] l_ctrl,
    input  logic [NUM_CH-1:0] r_ctrl,
    input  logic              load_valid,
    input  logic [3:0]        load_ch,
    input  logic [PW-1:0]     load_pulse,
    output logic              load_ready,
    output logic              load_err,
    output logic [NUM_CH-1:0] servo,
    output logic [NUM_CH-1:0] at_target
);
    localparam logic [PW-1:0] L_MIN    = PW'(PULSE_MIN);
    localparam logic [PW-1:0] L_MAX    = PW'(PULSE_MAX);
    localparam logic [PW-1:0] L_FT_M1  = PW'(FRAME_TICK - 1);
    localparam logic [PW-1:0] L_TK_M1  = PW'(SLOW_TICK_MAX - 1);
    localparam logic [PW-1:0] L_ONE    = PW'(1);
    localparam logic [4:0]    L_NCH    = 5'(NUM_CH);

    logic [PW-1:0] r_frame_cnt, r_tick_cnt;
    logic          r_load_ready, r_load_err;
    logic          w_tick, w_xfer, w_ld_ok;
    logic [PW-1:0] w_ld_val;

    assign w_tick   = (r_tick_cnt == L_TK_M1);
    assign w_xfer   = load_valid & r_load_ready;
    assign w_ld_ok  = ({1'b0, load_ch} < L_NCH);
    assign w_ld_val = (load_pulse < L_MIN) ? L_MIN :
                      (load_pulse > L_MAX) ? L_MAX : load_pulse;

    // Free-running frame and update-tick counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_cnt <= '0;
            r_tick_cnt  <= '0;
        end else begin
            r_frame_cnt <= (r_frame_cnt == L_FT_M1) ? '0 : r_frame_cnt + L_ONE;
            r_tick_cnt  <= w_tick ? '0 : r_tick_cnt + L_ONE;
        end
    end

    // Write handshake: ready drops for one cycle after every transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_load_ready <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_load_ready <= ~w_xfer;
            r_load_err   <= w_xfer & ~w_ld_ok;
        end
    end

    assign load_ready = r_load_ready;
    assign load_err   = r_load_err;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [PW-1:0] w_phase;
`ifdef SERVO_STAGGER_EN
        localparam int PW1 = PW + 1;
        localparam int OFS = k * (FRAME_TICK / NUM_CH);
        logic [PW:0] w_sum;
        assign w_sum   = {1'b0, r_frame_cnt} + PW1'(OFS);
        assign w_phase = (w_sum >= PW1'(FRAME_TICK)) ? PW'(w_sum - PW1'(FRAME_TICK)) : PW'(w_sum);
`else
        assign w_phase = r_frame_cnt;
`endif
        servo_ch #(
            .PW(PW), .FRAME_TICK(FRAME_TICK), .PULSE_MIN(PULSE_MIN),
            .PULSE_MAX(PULSE_MAX), .STEP_SIZE(STEP_SIZE)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .i_tick      (w_tick),
            .i_inc       (r_ctrl[k]),
            .i_dec       (l_ctrl[k]),
            .i_wr        (w_xfer & w_ld_ok & (load_ch == 4'(k))),
            .i_wr_val    (w_ld_val),
            .i_phase     (w_phase),
            .o_servo     (servo[k]),
            .o_at_target (at_target[k])
        );
    end
endmodule

// File: tb/tb_multi_servo_ctrl.sv
// tb_multi_servo_ctrl: scaled-down parameters so whole frames fit in a short
// run. A transaction-level reference model pushes the expected pulse width of
// every frame into a per-channel queue; a monitor measures each servo pulse
// and pops/compares on its falling edge. Handshake and at_target are compared
// against the model every cycle.

module tb_multi_servo_ctrl;
    localparam int NUM_CH = 4;
    localparam int FT     = 200;
    localparam int PMIN   = 4;
    localparam int PMAX   = 120;
    localparam int STEP   = 5;
    localparam int SLOW   = 64;
    localparam int PW     = 10;
    localparam int OFS    = FT / NUM_CH;
`ifdef SERVO_STAGGER_EN
    localparam int STAGGER = 1;
`else
    localparam int STAGGER = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NUM_CH-1:0] l_ctrl, r_ctrl;
    logic              load_valid;
    logic [3:0]        load_ch;
    logic [PW-1:0]     load_pulse;
    logic              load_ready, load_err;
    logic [NUM_CH-1:0] servo, at_target;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    multi_servo_ctrl #(
        .NUM_CH(NUM_CH), .FRAME_TICK(FT), .PULSE_MIN(PMIN), .PULSE_MAX(PMAX),
        .STEP_SIZE(STEP), .SLOW_TICK_MAX(SLOW), .PW(PW)
    ) dut (
        .clk(clk), .rst(rst), .l_ctrl(l_ctrl), .r_ctrl(r_ctrl),
        .load_valid(load_valid), .load_ch(load_ch), .load_pulse(load_pulse),
        .load_ready(load_ready), .load_err(load_err),
        .servo(servo), .at_target(at_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_tgt [NUM_CH];
    int m_pos [NUM_CH];
    int m_frame, m_tick;
    bit m_ready, m_err;
    int exp_q [NUM_CH][$];

    function automatic int phase_of(int f, int k);
        return (f + k * OFS * STAGGER) % FT;
    endfunction

    function automatic int clampv(int v);
        return (v < PMIN) ? PMIN : (v > PMAX) ? PMAX : v;
    endfunction

    function automatic int nxt_tgt(int k, bit xfer, bit tick);
        int t = m_tgt[k];
        if (tick && r_ctrl[k])      t = (t + STEP > PMAX) ? PMAX : t + STEP;
        else if (tick && l_ctrl[k]) t = (t - STEP < PMIN) ? PMIN : t - STEP;
        if (xfer && int'(load_ch) == k) t = clampv(int'(load_pulse));
        return t;
    endfunction

    function automatic int nxt_pos(int k, bit tick);
        int d = m_tgt[k] - m_pos[k];
        if (!tick)       return m_pos[k];
        if (d > STEP)    return m_pos[k] + STEP;
        if (d < -STEP)   return m_pos[k] - STEP;
        return m_tgt[k];
    endfunction

    function automatic logic [NUM_CH-1:0] exp_at();
        logic [NUM_CH-1:0] a;
        a = '0;
        for (int k = 0; k < NUM_CH; k++) a[k] = (m_pos[k] == m_tgt[k]);
        return a;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_frame <= 0;
            m_tick  <= 0;
            m_ready <= 1'b0;
            m_err   <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                m_tgt[k] <= PMIN;
                m_pos[k] <= PMIN;
                exp_q[k].delete();
                if (phase_of(0, k) == 0) exp_q[k].push_back(PMIN);
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                m_tgt[k] <= nxt_tgt(k, load_valid && m_ready, m_tick == SLOW - 1);
                m_pos[k] <= nxt_pos(k, m_tick == SLOW - 1);
                if (phase_of(m_frame, k) == FT - 1) exp_q[k].push_back(m_pos[k]);
            end
            m_ready <= !(load_valid && m_ready);
            m_err   <= load_valid && m_ready && (int'(load_ch) >= NUM_CH);
            m_frame <= (m_frame + 1) % FT;
            m_tick  <= (m_tick + 1) % SLOW;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int mon_cnt  [NUM_CH];
    bit mon_prev [NUM_CH];
    int rise     [NUM_CH] = '{default: -1};

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                mon_cnt[k]  <= 0;
                mon_prev[k] <= 1'b0;
            end
        end else begin
            chk("ready", load_ready, m_ready);
            chk("err", load_err, m_err);
            chk("at_target", at_target, exp_at());
            for (int k = 0; k < NUM_CH; k++) begin
                mon_prev[k] <= servo[k];
                if (servo[k]) begin
                    mon_cnt[k] <= mon_cnt[k] + 1;
                    if (!mon_prev[k] && rise[k] < 0) rise[k] <= cyc;
                end else begin
                    mon_cnt[k] <= 0;
                    if (mon_prev[k]) begin
                        if (exp_q[k].size() == 0) chk("sb_underflow", 0, 1);
                        else chk($sformatf("width_ch%0d", k), mon_cnt[k], exp_q[k].pop_front());
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ticks(input int n);
        repeat (n * SLOW) @(negedge clk);
    endtask

    task automatic wr(input int ch, input int val);
        load_valid = 1'b1;
        load_ch    = 4'(ch);
        load_pulse = PW'(val);
        @(negedge clk);
        load_valid = 1'b0;
        @(negedge clk);
    endtask

    // Bounded measurement of one full pulse on channel k; w stays -1 without a pulse.
    task automatic measure(input int k, output int w);
        w = -1;
        for (int i = 0; i < 2 * FT && servo[k]; i++) @(negedge clk);
        for (int i = 0; i < 2 * FT && !servo[k]; i++) @(negedge clk);
        if (servo[k]) begin
            w = 0;
            for (int i = 0; i < FT && servo[k]; i++) begin
                w++;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        int w;
        l_ctrl = '0; r_ctrl = '0;
        load_valid = 1'b0; load_ch = '0; load_pulse = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_servo", servo, 0);
        chk("rst_ready", load_ready, 0);
        chk("rst_err", load_err, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", load_ready, 1);

        // idle frames: every channel at minimum width, all at target
        repeat (3 * FT) @(negedge clk);
        chk("idle_at_target", at_target, 4'hF);
        for (int k = 0; k < NUM_CH; k++) begin
            chk("rise_seen", int'(rise[k] >= 0), 1);
            chk($sformatf("rise_ofs_ch%0d", k), (rise[k] - rise[0] + FT) % FT,
                (FT - k * OFS * STAGGER) % FT);
        end

        // direct write, position slews in STEP increments
        wr(1, 79);
        wait_ticks(20);
        chk("ch1_at_target", at_target[1], 1);
        measure(1, w);
        chk("ch1_width", w, 79);

        // ch0 ramps up to saturation (both buttons for a while: r wins);
        // ch3 ramps down through the low clamp
        wr(3, 14);
        r_ctrl[0] = 1'b1;
        l_ctrl[3] = 1'b1;
        wait_ticks(10);
        l_ctrl[0] = 1'b1;
        wait_ticks(10);
        l_ctrl[0] = 1'b0;
        wait_ticks(10);
        r_ctrl = '0;
        l_ctrl = '0;
        wait_ticks(5);
        chk("ch0_at_target", at_target[0], 1);
        measure(0, w);
        chk("ch0_sat_width", w, PMAX);
        measure(3, w);
        chk("ch3_min_width", w, PMIN);

        // invalid channel: error pulse, no target change
        load_valid = 1'b1;
        load_ch    = 4'(NUM_CH);
        load_pulse = PW'(60);
        @(negedge clk);
        load_valid = 1'b0;
        chk("err_pulse", load_err, 1);
        @(negedge clk);
        chk("err_clear", load_err, 0);
        chk("err_no_change", at_target, 4'hF);

        // out-of-range write is clamped
        wr(2, 500);
        wait_ticks(25);
        measure(2, w);
        chk("ch2_clamp_width", w, PMAX);

        // write coincides with update tick and r_ctrl on the same channel;
        // a second write the following cycle must not transfer
        for (int i = 0; i < SLOW + 2 && m_tick != SLOW - 1; i++) @(negedge clk);
        load_valid = 1'b1;
        load_ch    = 4'd2;
        load_pulse = PW'(50);
        r_ctrl[2]  = 1'b1;
        @(negedge clk);
        chk("b2b_ready_low", load_ready, 0);
        load_ch    = 4'd1;
        load_pulse = PW'(100);
        r_ctrl[2]  = 1'b0;
        @(negedge clk);
        load_valid = 1'b0;
        wait_ticks(20);
        measure(2, w);
        chk("ch2_write_wins", w, 50);
        measure(1, w);
        chk("ch1_not_written", w, 79);

        // reset in the middle of a pulse aborts it at once
        for (int i = 0; i < 2 * FT && !servo[0]; i++) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_servo", servo, 0);
        chk("midrst_ready", load_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2 * FT) @(negedge clk);
        measure(0, w);
        chk("post_rst_width", w, PMIN);
        chk("post_rst_at_target", at_target, 4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/multi_servo_ctrl.md
MULTI_SERVO_CTRL -- requirements
Module: multi_servo_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent servo channels (1..16).
REQ-002 Parameter FRAME_TICK, default 1000000: PWM frame length in clk cycles (20 ms at 50 MHz).
REQ-003 Parameter PULSE_MIN, default 35000: minimum pulse width in cycles (0 deg).
REQ-004 Parameter PULSE_MAX, default 115000: maximum pulse width in cycles (180 deg).
REQ-005 Parameter STEP_SIZE, default 2000: per-tick increment for button adjust and slew.
REQ-006 Parameter SLOW_TICK_MAX, default 5000000: update-tick period in cycles (0.1 s).
REQ-007 Parameter PW, default 25: width of all pulse, position and counter values.
REQ-008 clk  input  1  single system clock; all logic on rising edge.
REQ-009 rst  input  1  reset, asynchronous assert, active-low.
REQ-010 l_ctrl  input  NUM_CH  per-channel decrease request, level sampled at update tick.
REQ-011 r_ctrl  input  NUM_CH  per-channel increase request, level sampled at update tick.
REQ-012 load_valid  input  1  direct target write request.
REQ-013 load_ch  input  4  channel index for write.
REQ-014 load_pulse  input  PW  requested target pulse width.
REQ-015 load_ready  output  1  write accept; a write transfers when load_valid and load_ready are both high.
REQ-016 load_err  output  1  one-cycle pulse when a transferred write has load_ch >= NUM_CH.
REQ-017 servo  output  NUM_CH  PWM output per channel.
REQ-018 at_target  output  NUM_CH  high when channel position equals channel target.

Function
REQ-019 Frame counter counts 0..FRAME_TICK-1 and wraps to 0; tick counter counts 0..SLOW_TICK_MAX-1 and wraps; update tick = cycle where tick counter equals SLOW_TICK_MAX-1.
REQ-020 Each channel holds target, position and duty registers, each PW bits, all within [PULSE_MIN, PULSE_MAX] at all times.
REQ-021 On update tick: r_ctrl[k] high -> target[k] += STEP_SIZE, clamped to PULSE_MAX; else l_ctrl[k] high -> target[k] -= STEP_SIZE, clamped to PULSE_MIN; both high -> r_ctrl wins.
REQ-022 Subtraction clamp evaluated without underflow (compare target against PULSE_MIN+STEP_SIZE).
REQ-023 Transferred write with valid load_ch sets target[load_ch] to load_pulse clamped to [PULSE_MIN, PULSE_MAX], visible the next cycle.
REQ-024 Write and button update to same channel on same tick -> write wins; other channels update normally.
REQ-025 load_ready low for exactly one cycle following each transfer, high otherwise (back-to-back writes accepted every second cycle).
REQ-026 On update tick, position[k] moves toward the pre-tick target[k] by STEP_SIZE; if |target-position| <= STEP_SIZE position snaps to target.
REQ-027 duty[k] loads position[k] only when frame counter equals FRAME_TICK-1, so a frame never carries a changed pulse width.
REQ-028 servo[k] high when phase counter < duty[k], registered (one-cycle latency from counter).
REQ-029 at_target[k] combinational compare of position[k] and target[k].

Reset
REQ-030 While rst low: frame and tick counters 0, target/position/duty all PULSE_MIN, servo all 0, load_ready 0, load_err 0.
REQ-031 load_ready rises on the first clock edge after rst deasserts; reset mid-ramp or mid-frame aborts immediately, no partial pulse completes.

Configuration
REQ-032 Macro SERVO_STAGGER_EN defined: channel k phase counter = (frame counter + k*(FRAME_TICK/NUM_CH)) mod FRAME_TICK, so pulse starts are spread; duty reload for channel k occurs when its phase counter equals FRAME_TICK-1.
REQ-033 Macro SERVO_STAGGER_EN undefined: all channels use the frame counter directly; all pulses rise on the same cycle.

Verification
REQ-034 Reset release, no input, 3 frames -> every servo high exactly 35000 cycles per 1000000, load_ready 1, at_target all 1.
REQ-035 Write ch1=75000 -> after 20 ticks position[1]=75000, at_target[1] rises on that tick, servo[1] width changes only at frame boundaries in 2000-cycle steps.
REQ-036 r_ctrl[0] held 45 ticks -> target[0] saturates at 115000, never exceeds; l_ctrl and r_ctrl both high -> target increases.
REQ-037 Write load_ch=NUM_CH -> load_err one-cycle pulse, no target changes; write at 200000 -> target clamped to 115000.
REQ-038 Write and r_ctrl on same channel at update tick -> target equals write value; second write next cycle -> load_ready 0, not transferred.
REQ-039 With SERVO_STAGGER_EN, NUM_CH=4 -> channel k rising edge offset k*250000 cycles from channel 0; without it, all rise together.
